// File: rtl/spike_scheduler.sv
// spike_scheduler: in-order spike event FIFO with a timestep drain FSM.
// The optional macro SPIKE_SCHED_STALE_DROP_EN discards stale events and counts them.
// When the macro is undefined, stale events are issued like current ones and drop_count stays 0.
module spike_scheduler #(
    parameter int SPIKE_IDX_W = 14,
    parameter int TIME_W      = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SPIKE_IDX_W-1:0]       in_spike_idx,
    input  logic [TIME_W-1:0]            in_time,
    input  logic                         step,
    input  logic                         freeze,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SPIKE_IDX_W-1:0]       out_spike_idx,
    output logic [TIME_W-1:0]            out_time,
    output logic [TIME_W-1:0]            cur_time,
    output logic                         step_done,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [15:0]                  drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = SPIKE_IDX_W + TIME_W;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [EW-1:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [TIME_W-1:0]       r_cur_time;
    logic                    r_out_valid;
    logic [SPIKE_IDX_W-1:0]  r_out_idx;
    logic [TIME_W-1:0]       r_out_time;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_load;
    logic                    w_drop;
    logic                    w_out_free;
    logic                    w_cur;
    logic                    w_stale;
    logic                    w_issuable;
    logic [SPIKE_IDX_W-1:0]  w_head_idx;
    logic [TIME_W-1:0]       w_head_time;
    logic [TIME_W-1:0]       w_delta;

    assign w_full     = r_count == CW'(FIFO_DEPTH);
    assign w_empty    = r_count == '0;
    assign w_push     = in_valid && !w_full;
    assign {w_head_idx, w_head_time} = r_mem[r_rd_ptr];
    // Head age relative to the current timestep; a set MSB means the tag lies in the past.
    assign w_delta    = w_head_time - r_cur_time;
    assign w_cur      = w_delta == '0;
    assign w_stale    = !w_cur && w_delta[TIME_W-1];
    assign w_out_free = !r_out_valid || out_ready;
`ifdef SPIKE_SCHED_STALE_DROP_EN
    assign w_issuable = w_cur;
`else
    assign w_issuable = w_cur || w_stale;
`endif
    assign w_pop      = w_load || w_drop;

    assign in_ready      = !w_full;
    assign out_valid     = r_out_valid;
    assign out_spike_idx = r_out_idx;
    assign out_time      = r_out_time;
    assign cur_time      = r_cur_time;
    assign fifo_count    = r_count;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state, issue/drop decisions and the step_done pulse
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_drop    = 1'b0;
        step_done = 1'b0;
        case (r_state)
            S_IDLE:  w_next = step ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
                w_load = !w_empty && !freeze && w_issuable && w_out_free;
`ifdef SPIKE_SCHED_STALE_DROP_EN
                w_drop = !w_empty && w_stale;
`endif
                if ((w_empty || (!w_cur && !w_stale)) && !r_out_valid) w_next = S_DONE;
            end
            S_DONE: begin
                step_done = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Event storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_spike_idx, in_time};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Output register: loads on issue, holds until the downstream accepts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_time  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_head_idx;
            r_out_time  <= w_head_time;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Current timestep advances as the step completes, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_cur_time <= '0;
        else        r_cur_time <= (r_state == S_DONE) ? r_cur_time + TIME_W'(1) : r_cur_time;
    end

`ifdef SPIKE_SCHED_STALE_DROP_EN
    logic [15:0] r_drop_count;

    // Saturating count of discarded stale events
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_drop_count <= '0;
        else        r_drop_count <= (w_drop && r_drop_count != 16'hFFFF) ? r_drop_count + 16'd1 : r_drop_count;
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_spike_scheduler.sv
// tb_spike_scheduler: directed checks of spike_scheduler against a queue-level timestep model
module tb_spike_scheduler;
    localparam int IW = 14;
    localparam int TW = 8;

    typedef struct {
        logic [IW-1:0] idx;
        logic [TW-1:0] t;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_spike_idx = '0;
    logic [TW-1:0] in_time = '0;
    logic          step = 1'b0;
    logic          freeze = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_spike_idx;
    logic [TW-1:0] out_time;
    logic [TW-1:0] cur_time;
    logic          step_done;
    logic [4:0]    fifo_count;
    logic [15:0]   drop_count;

    ev_t           q[$];
    ev_t           exp_q[$];
    ev_t           e;
    int            hs_cyc[$];
    int            cyc = 0;
    int            done_cnt = 0;
    int            m_drop = 0;
    logic [TW-1:0] m_cur = '0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            n0;
    bit            p_stall = 0;
    logic [IW-1:0] p_idx;
    logic [TW-1:0] p_time;

    spike_scheduler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_spike_idx(in_spike_idx), .in_time(in_time), .step(step), .freeze(freeze),
        .out_valid(out_valid), .out_ready(out_ready), .out_spike_idx(out_spike_idx),
        .out_time(out_time), .cur_time(cur_time), .step_done(step_done),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int t);
        in_valid = 1'b1;
        in_spike_idx = IW'(idx);
        in_time = TW'(t);
        @(posedge clk); #1;
        in_valid = 1'b0;
        q.push_back('{IW'(idx), TW'(t)});
    endtask

    task automatic model_step();
        logic [TW-1:0] d;
        bit go = 1;
        while (go && q.size() > 0) begin
            d = q[0].t - m_cur;
            if (d == '0 || d[TW-1]) begin
`ifdef SPIKE_SCHED_STALE_DROP_EN
                if (d == '0) exp_q.push_back(q[0]);
                else if (m_drop < 65535) m_drop++;
`else
                exp_q.push_back(q[0]);
`endif
                void'(q.pop_front());
            end else go = 0;
        end
    endtask

    task automatic step_start();
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        model_step();
    endtask

    task automatic wait_done(input string name);
        int start = done_cnt;
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            ok = done_cnt != start;
        end
        chk({name, "_done_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            ok = out_valid;
        end
        chk({name, "_valid_seen"}, 32'(ok), 1);
    endtask

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            p_stall = 0;
            exp_q.delete();
            m_cur = '0;
            m_drop = 0;
        end else begin
            if (p_stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_idx", 32'(out_spike_idx), 32'(p_idx));
                chk("hold_time", 32'(out_time), 32'(p_time));
            end
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_issue: idx %0d time %0d, nothing pending", out_spike_idx, out_time);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_idx", 32'(out_spike_idx), 32'(e.idx));
                    chk("issue_time", 32'(out_time), 32'(e.t));
                end
            end
            if (step_done) begin
                chk("done_cur_time", 32'(cur_time), 32'(m_cur));
                chk("done_pending", 32'(exp_q.size()), 0);
                chk("done_fifo_count", 32'(fifo_count), 32'(q.size()));
                chk("done_drop_count", 32'(drop_count), 32'(m_drop));
                m_cur = m_cur + 8'd1;
                done_cnt++;
            end
            p_stall = out_valid && !out_ready;
            p_idx = out_spike_idx;
            p_time = out_time;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_cur_time", 32'(cur_time), 0);
        chk("rst_step_done", 32'(step_done), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_out_idx", 32'(out_spike_idx), 0);
        chk("rst_out_time", 32'(out_time), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        out_ready = 1'b1;
        push(5, 0); push(10, 0); push(15, 0);
        n0 = hs_cyc.size();
        step_start();
        wait_done("basic");
        chk("basic_issued", 32'(hs_cyc.size() - n0), 3);
        if (hs_cyc.size() >= n0 + 3) begin
            chk("basic_consec_1", 32'(hs_cyc[n0+1] - hs_cyc[n0]), 1);
            chk("basic_consec_2", 32'(hs_cyc[n0+2] - hs_cyc[n0+1]), 1);
        end
        chk("basic_cur_time", 32'(cur_time), 1);
        chk("basic_fifo_count", 32'(fifo_count), 0);

        push(3, 1); push(4, 2);
        n0 = hs_cyc.size();
        step_start();
        wait_done("future1");
        chk("future1_issued", 32'(hs_cyc.size() - n0), 1);
        chk("future1_fifo_count", 32'(fifo_count), 1);
        step_start();
        wait_done("future2");
        chk("future2_issued", 32'(hs_cyc.size() - n0), 2);
        chk("future2_cur_time", 32'(cur_time), 3);

        push(7, 1);
        n0 = hs_cyc.size();
        step_start();
        wait_done("stale");
`ifdef SPIKE_SCHED_STALE_DROP_EN
        chk("stale_drop_count", 32'(drop_count), 1);
        chk("stale_issued", 32'(hs_cyc.size() - n0), 0);
`else
        chk("stale_drop_count", 32'(drop_count), 0);
        chk("stale_issued", 32'(hs_cyc.size() - n0), 1);
`endif

        out_ready = 1'b0;
        push(20, 4); push(21, 4);
        step_start();
        wait_valid("freeze");
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("freeze_valid", 32'(out_valid), 1);
            chk("freeze_idx", 32'(out_spike_idx), 20);
            chk("freeze_fifo_count", 32'(fifo_count), 1);
        end
        freeze = 1'b0;
        out_ready = 1'b1;
        wait_done("freeze");
        chk("freeze_cur_time", 32'(cur_time), 5);

        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(100 + i, 5);
        chk("full_fifo_count", 32'(fifo_count), 16);
        chk("full_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_spike_idx = IW'(999);
        in_time = TW'(5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_reject_count", 32'(fifo_count), 16);
        step_start();
        wait_valid("full_pop");
        chk("full_pop_count", 32'(fifo_count), 15);
        chk("full_pop_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        wait_done("full");
        chk("full_cur_time", 32'(cur_time), 6);

        for (int i = 0; i < 300 && m_cur != 8'd255; i++) begin
            step_start();
            wait_done("wrap_walk");
        end
        chk("wrap_at_255", 32'(cur_time), 255);
        push(55, 255);
        step_start();
        wait_done("wrap");
        chk("wrap_cur_time", 32'(cur_time), 0);

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(60 + i, 0);
        step_start();
        wait_valid("mid_reset");
        chk("mid_reset_buffered", 32'(fifo_count), 4);
        #1;
        reset = 1'b0;
        #1;
        q.delete();
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_fifo_count", 32'(fifo_count), 0);
        chk("mrst_cur_time", 32'(cur_time), 0);
        chk("mrst_step_done", 32'(step_done), 0);
        chk("mrst_drop_count", 32'(drop_count), 0);
        chk("mrst_out_idx", 32'(out_spike_idx), 0);
        chk("mrst_out_time", 32'(out_time), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_in_ready", 32'(in_ready), 1);
        chk("mrst_fifo_empty", 32'(fifo_count), 0);
        out_ready = 1'b1;
        n0 = hs_cyc.size();
        push(9, 0);
        step_start();
        wait_done("post_reset");
        chk("post_reset_issued", 32'(hs_cyc.size() - n0), 1);
        chk("post_reset_cur_time", 32'(cur_time), 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
